// File: rtl/mcs4_axi_loader.sv
// Single-command AXI4 burst initiator for the mcs4_sys slave port.
// Write and read streams pass straight through; completion is signalled by a done/err pulse.
module mcs4_axi_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR, S_R} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  flag_q, flag_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic in_w, in_r, last, w_hs, r_hs, beat_bad;

  assign in_w     = (state_q == S_W);
  assign in_r     = (state_q == S_R);
  assign last     = (cnt_q == {1'b0, len_q});
  assign w_hs     = in_w && wr_valid && m_axi_wready;
  assign r_hs     = in_r && m_axi_rvalid && rd_ready;
  // The slave's rlast is only checked, never trusted to end the burst.
  assign beat_bad = (m_axi_rresp != 2'b00) || (m_axi_rlast != last);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
        len_d   = cmd_len;
        cnt_d   = 9'd0;
        flag_d  = 1'b0;
        state_d = cmd_write ? S_AW : S_AR;
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: if (w_hs) begin
        cnt_d = cnt_q + 9'd1;
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: if (r_hs) begin
        cnt_d  = cnt_q + 9'd1;
        flag_d = flag_q || beat_bad;
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = flag_q || beat_bad;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // cmd_ready is gated by rst so it is low for the whole reset window.
  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awvalid = (state_q == S_AW);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arvalid = (state_q == S_AR);

  assign m_axi_wvalid  = in_w && wr_valid;
  assign wr_ready      = in_w && m_axi_wready;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_wlast   = in_w && last;

  assign rd_valid      = in_r && m_axi_rvalid;
  assign m_axi_rready  = in_r && rd_ready;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = in_r && last;

endmodule

// File: tb/tb_mcs4_axi_loader.sv
// Bench for mcs4_axi_loader: word-memory AXI slave, write source / read sink,
// and a transaction-level model compared against the DUT every cycle.
module tb_mcs4_axi_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done, err, busy;
  logic [13:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  mcs4_axi_loader #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Stimulus controls written by the main sequence only.
  logic [31:0] src_data [0:1023];
  logic [3:0]  src_strb [0:1023];
  int          src_n = 0;
  bit          gap_en = 1'b0;
  int          inj_resp = -1;
  int          inj_rlast = -1;

  // Environment: slave memory, write source, read sink. Samples at negedge, drives 1ns after posedge.
  logic [31:0] mem [0:4095];
  int          src_head, wptr, rptr, rbeat, rtot;
  initial begin : env
    logic        s_rst, s_aw, s_w, s_ar, s_r, s_wr;
    logic [13:0] s_awaddr, s_araddr;
    logic [7:0]  s_arlen;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    src_head = 0; wptr = 0; rptr = 0; rbeat = 0; rtot = 0;
    m_axi_awready = 1'b0; m_axi_arready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_aw = m_axi_awvalid && m_axi_awready; s_awaddr = m_axi_awaddr;
      s_w  = m_axi_wvalid && m_axi_wready;   s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
      s_ar = m_axi_arvalid && m_axi_arready; s_araddr = m_axi_araddr; s_arlen = m_axi_arlen;
      s_r  = m_axi_rvalid && m_axi_rready;
      s_wr = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (s_rst) begin
        m_axi_rvalid = 1'b0; rbeat = 0; rtot = 0; src_head = src_n; wr_valid = 1'b0;
      end else begin
        if (s_aw) wptr = int'(s_awaddr >> 2);
        if (s_w) begin
          for (int b = 0; b < 4; b++) if (s_wstrb[b]) mem[wptr][8*b +: 8] = s_wdata[8*b +: 8];
          wptr++;
        end
        if (s_ar) begin rptr = int'(s_araddr >> 2); rtot = int'(s_arlen) + 1; rbeat = 0; end
        if (s_r) begin rbeat++; rptr++; end
        if (s_wr) src_head++;
        if (!m_axi_rvalid || s_r)
          m_axi_rvalid = (rbeat < rtot) && (!gap_en || $urandom_range(0, 1) == 1);
        if (m_axi_rvalid) begin
          m_axi_rdata = mem[rptr];
          m_axi_rresp = (rbeat == inj_resp) ? 2'd2 : 2'd0;
          m_axi_rlast = (rbeat == inj_rlast) || (rbeat == rtot - 1);
        end
        wr_valid = (src_head < src_n) && (!gap_en || $urandom_range(0, 1) == 1);
        if (src_head < src_n) begin wr_data = src_data[src_head]; wr_strb = src_strb[src_head]; end
      end
      m_axi_awready = !gap_en || ($urandom_range(0, 2) == 0);
      m_axi_arready = !gap_en || ($urandom_range(0, 2) == 0);
      m_axi_wready  = !gap_en || ($urandom_range(0, 1) == 1);
      rd_ready      = !gap_en || ($urandom_range(0, 1) == 1);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h want=%0h", n, got, exp);
    end
  endtask

  // Transaction model state, written only by the monitor.
  bit          m_active = 0, m_write = 0, m_addr_done = 0, m_flag = 0, done_due = 0, err_due = 0;
  logic [13:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  int          m_beat = 0;
  int          w_beats = 0, w_lasts = 0, r_beats = 0, r_lasts = 0;
  logic [13:0] last_awaddr = '0;
  logic [7:0]  last_awlen = '0;
  logic [31:0] rd_got [$];

  task automatic mon_step();
    bit aph, wph, rph, lastb, bb;
    if (rst) begin
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      m_active = 0; done_due = 0;
      return;
    end
    aph   = m_active && !m_addr_done;
    wph   = m_active && m_write && m_addr_done;
    rph   = m_active && !m_write && m_addr_done;
    lastb = (m_beat == int'(m_len));
    chk("busy", 64'(busy), 64'(m_active));
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_active));
    chk("awvalid", 64'(m_axi_awvalid), 64'(aph && m_write));
    chk("arvalid", 64'(m_axi_arvalid), 64'(aph && !m_write));
    if (m_axi_awvalid) begin
      chk("awaddr", 64'(m_axi_awaddr), 64'(m_addr));
      chk("awlen", 64'(m_axi_awlen), 64'(m_len));
    end
    if (m_axi_arvalid) begin
      chk("araddr", 64'(m_axi_araddr), 64'(m_addr));
      chk("arlen", 64'(m_axi_arlen), 64'(m_len));
    end
    chk("wvalid", 64'(m_axi_wvalid), 64'(wph && wr_valid));
    chk("wr_ready", 64'(wr_ready), 64'(wph && m_axi_wready));
    if (wph && m_axi_wvalid) begin
      chk("wdata", 64'(m_axi_wdata), 64'(wr_data));
      chk("wstrb", 64'(m_axi_wstrb), 64'(wr_strb));
      chk("wlast", 64'(m_axi_wlast), 64'(lastb));
    end
    chk("rd_valid", 64'(rd_valid), 64'(rph && m_axi_rvalid));
    chk("rready", 64'(m_axi_rready), 64'(rph && rd_ready));
    if (rph && rd_valid) begin
      chk("rd_data", 64'(rd_data), 64'(m_axi_rdata));
      chk("rd_last", 64'(rd_last), 64'(lastb));
    end
    chk("done", 64'(done), 64'(done_due));
    if (done_due) chk("err", 64'(err), 64'(err_due));
    done_due = 0;
    if (!m_active) begin
      if (cmd_valid) begin
        m_active = 1; m_write = cmd_write; m_addr = {cmd_addr[13:2], 2'b00};
        m_len = cmd_len; m_beat = 0; m_flag = 0; m_addr_done = 0;
      end
    end else if (!m_addr_done) begin
      if (m_write ? (m_axi_awvalid && m_axi_awready) : (m_axi_arvalid && m_axi_arready)) begin
        m_addr_done = 1;
        if (m_write) begin last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen; end
      end
    end else if (m_write) begin
      if (m_axi_wvalid && m_axi_wready) begin
        w_beats++;
        if (m_axi_wlast) w_lasts++;
        if (lastb) begin m_active = 0; done_due = 1; err_due = 0; end
        else m_beat++;
      end
    end else if (rd_valid && rd_ready) begin
      r_beats++;
      if (rd_last) r_lasts++;
      rd_got.push_back(rd_data);
      bb = (m_axi_rresp != 2'd0) || (m_axi_rlast != lastb);
      m_flag = m_flag || bb;
      if (lastb) begin m_active = 0; done_due = 1; err_due = m_flag; end
      else m_beat++;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] s);
    src_data[src_n] = d;
    src_strb[src_n] = s;
    src_n++;
  endtask

  task automatic send_cmd(input bit wr, input logic [13:0] a, input logic [7:0] l);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_accepted", 64'(ok), 64'(1));
  endtask

  task automatic run_cmd(input bit wr, input logic [13:0] a, input logic [7:0] l, output bit e);
    bit ok;
    ok = 0; e = 0;
    send_cmd(wr, a, l);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; e = err; break; end
    end
    chk("done_seen", 64'(ok), 64'(1));
  endtask

  int          wb0, wl0, rb0, rl0, rg0;
  bit          e, ok;
  logic [31:0] bp_exp [0:15];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    fork
      forever begin @(negedge clk); mon_step(); end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_awvalid", 64'(m_axi_awvalid), 64'(0));
        chk("reset_arvalid", 64'(m_axi_arvalid), 64'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Single-beat write and readback.
        push(32'hDEADBEEF, 4'hF);
        wb0 = w_beats; wl0 = w_lasts;
        run_cmd(1, 14'h0004, 8'd0, e);
        chk("single_awaddr", 64'(last_awaddr), 64'h0004);
        chk("single_awlen", 64'(last_awlen), 64'h0);
        chk("single_wbeats", 64'(w_beats - wb0), 64'd1);
        chk("single_wlast", 64'(w_lasts - wl0), 64'd1);
        chk("single_err", 64'(e), 64'(0));
        rg0 = rd_got.size();
        run_cmd(0, 14'h0004, 8'd0, e);
        chk("single_read", 64'(rd_got[rg0]), 64'hDEADBEEF);
        chk("single_read_err", 64'(e), 64'(0));

        // Partial strobe merges into the existing word.
        push(32'h11223344, 4'h5);
        run_cmd(1, 14'h0004, 8'd0, e);
        rg0 = rd_got.size();
        run_cmd(0, 14'h0004, 8'd0, e);
        chk("strobe_read", 64'(rd_got[rg0]), 64'hDE22BE44);

        // Maximum 256-beat burst.
        for (int i = 0; i < 256; i++) push(32'hA5000000 + i, 4'hF);
        wb0 = w_beats; wl0 = w_lasts;
        run_cmd(1, 14'h0100, 8'd255, e);
        chk("max_wbeats", 64'(w_beats - wb0), 64'd256);
        chk("max_wlast", 64'(w_lasts - wl0), 64'd1);
        chk("max_err", 64'(e), 64'(0));
        rb0 = r_beats; rl0 = r_lasts; rg0 = rd_got.size();
        run_cmd(0, 14'h0100, 8'd255, e);
        chk("max_rbeats", 64'(r_beats - rb0), 64'd256);
        chk("max_rlast", 64'(r_lasts - rl0), 64'd1);
        chk("max_read_err", 64'(e), 64'(0));
        for (int i = 0; i < 256; i++) chk("max_data", 64'(rd_got[rg0 + i]), 64'(32'hA5000000 + i));

        // Backpressure on every channel.
        gap_en = 1'b1;
        for (int i = 0; i < 16; i++) begin bp_exp[i] = $urandom; push(bp_exp[i], 4'hF); end
        wb0 = w_beats;
        run_cmd(1, 14'h0200, 8'd15, e);
        chk("bp_wbeats", 64'(w_beats - wb0), 64'd16);
        rb0 = r_beats; rg0 = rd_got.size();
        run_cmd(0, 14'h0200, 8'd15, e);
        chk("bp_rbeats", 64'(r_beats - rb0), 64'd16);
        chk("bp_err", 64'(e), 64'(0));
        for (int i = 0; i < 16; i++) chk("bp_data", 64'(rd_got[rg0 + i]), 64'(bp_exp[i]));
        gap_en = 1'b0;

        // Read errors: bad rresp on beat 1, then early rlast on beat 2.
        inj_resp = 0;
        rb0 = r_beats;
        run_cmd(0, 14'h0100, 8'd3, e);
        chk("rresp_err", 64'(e), 64'(1));
        chk("rresp_beats", 64'(r_beats - rb0), 64'd4);
        inj_resp = -1; inj_rlast = 1;
        rb0 = r_beats;
        run_cmd(0, 14'h0100, 8'd3, e);
        chk("rlast_err", 64'(e), 64'(1));
        chk("rlast_beats", 64'(r_beats - rb0), 64'd4);
        inj_rlast = -1;
        run_cmd(0, 14'h0100, 8'd3, e);
        chk("clean_after_err", 64'(e), 64'(0));

        // Reset in the middle of an 8-beat write.
        for (int i = 0; i < 8; i++) push(32'h50000000 + i, 4'hF);
        wb0 = w_beats;
        send_cmd(1, 14'h0300, 8'd7);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (w_beats - wb0 >= 2) begin ok = 1; break; end
        end
        chk("rst_beats_reached", 64'(ok), 64'(1));
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_wvalid", 64'(m_axi_wvalid), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_partial", 64'(w_beats - wb0 < 8), 64'(1));
        repeat (3) begin @(negedge clk); chk("midrst_no_done", 64'(done), 64'(0)); end

        // Unaligned single-beat write after reset.
        push(32'hCAFEF00D, 4'hF);
        run_cmd(1, 14'h0007, 8'd0, e);
        chk("unaligned_awaddr", 64'(last_awaddr), 64'h0004);
        chk("unaligned_err", 64'(e), 64'(0));
        rg0 = rd_got.size();
        run_cmd(0, 14'h0004, 8'd0, e);
        chk("unaligned_read", 64'(rd_got[rg0]), 64'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end
endmodule

// File: doc/mcs4_axi_loader.md
# mcs4_axi_loader

AXI4 burst initiator that drives the slave AXI port of `mcs4_sys` from a simple command/stream interface, used by the system bench and the host-side bring-up path to load ROM images and read back RAM/ROM state. Accepts one command at a time, runs a single INCR-style write or read burst of 1–256 beats, and reports completion and error status. Write data and read data pass through without buffering. No B channel is used: a write completes on the `wlast` handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, 14, AXI byte-address width.
- `DATA_WIDTH`, 32, AXI data width; must be a multiple of 8.

Ports:
- `clk` in 1: single clock. Also drives `s_axi_aclk` of `mcs4_sys`.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_WIDTH: start byte address.
- `cmd_len` in 8: number of beats minus 1.
- `wr_data` in DATA_WIDTH: write stream data.
- `wr_strb` in DATA_WIDTH/8: write stream byte enables.
- `wr_valid` in 1: write stream valid.
- `wr_ready` out 1: write stream ready.
- `rd_data` out DATA_WIDTH: read stream data.
- `rd_last` out 1: final beat of the read stream.
- `rd_valid` out 1: read stream valid.
- `rd_ready` in 1: read stream ready.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: status for the completed command; valid only with `done`.
- `busy` out 1: high whenever the block is not in IDLE.
- `m_axi_awaddr`, `m_axi_awlen`, `m_axi_awvalid`, `m_axi_awready`, `m_axi_wdata`, `m_axi_wstrb`, `m_axi_wlast`, `m_axi_wvalid`, `m_axi_wready`, `m_axi_araddr`, `m_axi_arlen`, `m_axi_arvalid`, `m_axi_arready`, `m_axi_rdata`, `m_axi_rresp`, `m_axi_rlast`, `m_axi_rvalid`, `m_axi_rready`: master-side AXI4 subset. Widths match the `mcs4_sys` slave ports: address ADDR_WIDTH, length 8, response 2.

## Operation
State machine: IDLE, AW, W, AR, R.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch the address with bits [1:0] forced to 0, latch `cmd_len`, clear the beat counter and the error flag.
  - Go to AW if `cmd_write`=1, else AR.
- **AW**
  - `m_axi_awvalid`=1 with the latched address and length, held stable until `m_axi_awready`.
  - On the handshake, go to W.
- **W**
  - Combinational pass-through:
    - `m_axi_wvalid`=`wr_valid`
    - `wr_ready`=`m_axi_wready`
    - `m_axi_wdata`/`m_axi_wstrb` come from `wr_data`/`wr_strb`.
  - `m_axi_wlast`=(count==len).
  - The counter increments on each W handshake.
  - On the handshake with `wlast`: go to IDLE and pulse `done`; `err`=0.
- **AR**
  - Mirror of AW, using `m_axi_arvalid`/`m_axi_arready`.
  - On the handshake, go to R.
- **R**
  - Combinational pass-through:
    - `rd_valid`=`m_axi_rvalid`
    - `m_axi_rready`=`rd_ready`
    - `rd_data`=`m_axi_rdata`
  - `rd_last`=(count==len). It is generated locally, not taken from the slave.
  - On each beat, set the sticky error flag if `m_axi_rresp`≠0 or `m_axi_rlast`≠(count==len).
  - The burst terminates on the handshake at count==len, whatever `m_axi_rlast` does. Go to IDLE and pulse `done`, with `err` = the sticky flag OR'd with the current beat's check.
- Counter is 9 bits wide. `cmd_len`=255 gives 256 beats with no wrap.
- Beats beyond `wr_valid`/`rd_ready` stall: the block waits indefinitely, with no timeout.
- In IDLE, AW and AR: `wr_ready`=0 and `rd_valid`=0.

## Timing
- Reset: state IDLE, all `*valid` outputs 0, `done`=0, `err`=0, `busy`=0. `cmd_ready` is 0 while `rst`=1 and 1 on the first cycle after reset.
- Reset mid-burst: return to IDLE on the next edge and drop all valids at once. No `done` pulse. The slave is reset by the same signal.
- Command accepted at edge N → `awvalid`/`arvalid` high in cycle N+1.
- An address handshake at edge M allows the first data beat in cycle M+1.
- The data path adds zero cycles of latency in both directions.
- Last data handshake at edge K → `done`=1 in cycle K+1 only. `cmd_ready`=1 in cycle K+1, so back-to-back commands lose one cycle.
- Address and data channels are strictly sequential: W is never asserted before the AW handshake.

## Test plan
- **Single-beat write:** write at addr 0x0004, len 0, data 0xDEADBEEF, strb 0xF. Required:
  - `awaddr`=0x0004, `awlen`=0.
  - One W beat with `wlast`=1.
  - `done` one cycle later with `err`=0.
  - Readback of 0x0004 returns 0xDEADBEEF.
- **Max burst:** write at addr 0x0100, len 255, incrementing data. Required:
  - 256 W beats, `wlast` only on beat 256.
  - Readback with len 255: 256 beats in order, `rd_last` only on beat 256, `err`=0.
- **Backpressure:** random `wr_valid`/`rd_ready` gaps plus slave `awready` delays. Required:
  - Address fields and `awvalid` held stable while stalled.
  - No beat lost or duplicated; data matches.
- **Read error:** slave model returns `rresp`=2 on beat 1 of 4, or asserts `rlast` early on beat 2 of 4. Required: exactly 4 beats consumed, `done` with `err`=1.
- **Reset mid-burst:** assert `rst` during beat 3 of an 8-beat write. Required:
  - Next cycle: IDLE, `wvalid`=0, no `done`.
  - After reset, a new single-beat command completes normally.
- **Unaligned address:** `cmd_addr`=0x0007. Required: `awaddr`=0x0004.
